// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead receive FIFO.
// The raw RXD pin is synchronised, framed by a five-state FSM and pushed into
// a small FIFO. Sticky overrun and framing-error flags are kept for firmware.
module uart_rx_fifo #(
  parameter int DIV_W   = 16,
  parameter int FIFO_AW = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [DIV_W-1:0]   baud_div_i,
  input  logic               rxd_i,
  input  logic               rd_i,
  input  logic               clr_err_i,
  output logic [7:0]         data_o,
  output logic               valid_o,
  output logic [FIFO_AW:0]   count_o,
  output logic               busy_o,
  output logic               overrun_o,
  output logic               frame_err_o
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(4);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_e;

  state_e             state_q, state_d;
  logic               sync1_q, rxs_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   timer_q, timer_d;
  logic [2:0]         bitCnt_q, bitCnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               push, frameErrSet;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wrPtr_q, rdPtr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overrun_q, frameErr_q;

  logic [DIV_W-1:0]   divClamped;
  logic               timerDone, full, pop, write, ovrSet;

  assign divClamped = (baud_div_i < MIN_DIV) ? MIN_DIV : baud_div_i;
  assign timerDone  = (timer_q == DIV_W'(1));

  // Two-flop synchroniser; both stages reset to the idle-high line level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd_i;
      rxs_q   <= sync1_q;
    end
  end

  // Receiver next-state logic: bit timing, data shifting and stop-bit decision.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    timer_d     = timer_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frameErrSet = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          div_d   = divClamped;
          timer_d = divClamped >> 1;
          state_d = START;
        end
      end
      START: begin
        if (timerDone) begin
          if (!rxs_q) begin
            timer_d  = div_q;
            bitCnt_d = 3'd0;
            state_d  = DATA;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (timerDone) begin
          shift_d  = {rxs_q, shift_q[7:1]};
          timer_d  = div_q;
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      STOP: begin
        if (timerDone) begin
          if (rxs_q) begin
            push        = 1'b1;
            state_d     = IDLE;
          end else begin
            frameErrSet = 1'b1;
            state_d     = WAIT_HI;
          end
        end else begin
          timer_d = timer_q - DIV_W'(1);
        end
      end
      WAIT_HI: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Receiver state register; reset abandons any partial frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      div_q    <= MIN_DIV;
      timer_q  <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      timer_q  <= timer_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
    end
  end

  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign full   = (count_q == FULL_CNT);
  assign pop    = rd_i && (count_q != '0);
  assign write  = push && (!full || pop);
  assign ovrSet = push && full && !pop;

  // Occupancy tracking, independent of the wrapping pointers.
  always_comb begin
    count_d = count_q;
    if (write && !pop)      count_d = count_q + (FIFO_AW + 1)'(1);
    else if (!write && pop) count_d = count_q - (FIFO_AW + 1)'(1);
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (write) mem_q[wrPtr_q] <= shift_q;
  end

  // FIFO pointers, occupancy and sticky error flags (a new error beats a clear).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      if (write) wrPtr_q <= wrPtr_q + FIFO_AW'(1);
      if (pop)   rdPtr_q <= rdPtr_q + FIFO_AW'(1);
      count_q    <= count_d;
      overrun_q  <= ovrSet      | (overrun_q  & ~clr_err_i);
      frameErr_q <= frameErrSet | (frameErr_q & ~clr_err_i);
    end
  end

  assign data_o      = mem_q[rdPtr_q];
  assign valid_o     = (count_q != '0);
  assign count_o     = count_q;
  assign busy_o      = (state_q != IDLE);
  assign overrun_o   = overrun_q;
  assign frame_err_o = frameErr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives serial frames into uart_rx_fifo and compares the
// FIFO outputs and flags against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] baud_div_i = 16'd16;
  logic        rxd_i = 1'b1;
  logic        rd_i = 1'b0;
  logic        clr_err_i = 1'b0;
  logic [7:0]  data_o;
  logic        valid_o;
  logic [2:0]  count_o;
  logic        busy_o;
  logic        overrun_o;
  logic        frame_err_o;

  int          vectors = 0;
  int          miscompares = 0;

  logic [7:0]  expQ [$];
  logic        expOvr = 1'b0;
  logic        expFerr = 1'b0;

  localparam int MODEL_DEPTH = 4;

  uart_rx_fifo #(.DIV_W(16), .FIFO_AW(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .baud_div_i  (baud_div_i),
    .rxd_i       (rxd_i),
    .rd_i        (rd_i),
    .clr_err_i   (clr_err_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .count_o     (count_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o),
    .frame_err_o (frame_err_o)
  );

  // Free-running system clock.
  always #5 clk_i = ~clk_i;

  // Model: a good byte lands in the buffer unless it is full, then it is lost.
  function automatic void modelGoodByte(input logic [7:0] b);
    if (expQ.size() == MODEL_DEPTH) expOvr = 1'b1;
    else expQ.push_back(b);
  endfunction

  // Serial frame driver: start, 8 data bits LSB first, stop (or a held-low
  // stop of stopLowClks cycles), then one idle bit time. Called at a negedge.
  task automatic sendFrame(input logic [7:0] b, input int bitClks, input int stopLowClks);
    rxd_i = 1'b0;
    repeat (bitClks) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rxd_i = b[i];
      repeat (bitClks) @(negedge clk_i);
    end
    if (stopLowClks > 0) begin
      rxd_i = 1'b0;
      repeat (stopLowClks) @(negedge clk_i);
    end
    rxd_i = 1'b1;
    repeat (2 * bitClks) @(negedge clk_i);
  endtask

  task automatic popOne();
    rd_i = 1'b1;
    @(negedge clk_i);
    rd_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    rxd_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_count got %0d want 0", count_o); end
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", valid_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy_o); end
    vectors++; if ({overrun_o, frame_err_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_flags got %b%b want 00", overrun_o, frame_err_o); end
  endtask

  task automatic test_single_byte();
    int n;
    baud_div_i = 16'd16;
    fork
      sendFrame(8'hA5, 16, 0);
      begin
        n = 0;
        while (valid_o !== 1'b1 && n < 400) begin
          @(negedge clk_i);
          n++;
        end
      end
    join
    modelGoodByte(8'hA5);
    vectors++; if (n < 150 || n > 160) begin miscompares++; $display("[TB] FAIL single_latency got %0d cycles want 150..160", n); end
    vectors++; if (data_o !== expQ[0]) begin miscompares++; $display("[TB] FAIL single_data got %h want %h", data_o, expQ[0]); end
    vectors++; if (count_o !== 3'(expQ.size())) begin miscompares++; $display("[TB] FAIL single_count got %0d want %0d", count_o, expQ.size()); end
    popOne();
    void'(expQ.pop_front());
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL single_pop_valid got %b want 0", valid_o); end
  endtask

  task automatic test_glitch();
    bit sawBusy = 1'b0;
    rxd_i = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      if (busy_o === 1'b1) sawBusy = 1'b1;
    end
    rxd_i = 1'b1;
    repeat (30) begin
      @(negedge clk_i);
      if (busy_o === 1'b1) sawBusy = 1'b1;
    end
    vectors++; if (sawBusy !== 1'b1) begin miscompares++; $display("[TB] FAIL glitch_busy_seen got %b want 1", sawBusy); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL glitch_busy_end got %b want 0", busy_o); end
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("[TB] FAIL glitch_count got %0d want 0", count_o); end
    vectors++; if ({overrun_o, frame_err_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL glitch_flags got %b%b want 00", overrun_o, frame_err_o); end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) begin
      sendFrame(8'(i), 16, 0);
      modelGoodByte(8'(i));
    end
    vectors++; if (count_o !== 3'(expQ.size())) begin miscompares++; $display("[TB] FAIL ovr_count got %0d want %0d", count_o, expQ.size()); end
    vectors++; if (overrun_o !== expOvr) begin miscompares++; $display("[TB] FAIL ovr_flag got %b want %b", overrun_o, expOvr); end
    while (expQ.size() > 0) begin
      vectors++; if (data_o !== expQ[0]) begin miscompares++; $display("[TB] FAIL ovr_pop got %h want %h", data_o, expQ[0]); end
      popOne();
      void'(expQ.pop_front());
    end
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL ovr_drained got %b want 0", valid_o); end
    clr_err_i = 1'b1;
    @(negedge clk_i);
    clr_err_i = 1'b0;
    expOvr = 1'b0;
    vectors++; if (overrun_o !== expOvr) begin miscompares++; $display("[TB] FAIL ovr_clear got %b want %b", overrun_o, expOvr); end
  endtask

  task automatic test_random();
    int div;
    int npop;
    logic [7:0] b;
    for (int k = 0; k < 10; k++) begin
      div = $urandom_range(5, 20);
      baud_div_i = 16'(div);
      b = 8'($urandom);
      sendFrame(b, div, 0);
      modelGoodByte(b);
      vectors++; if (count_o !== 3'(expQ.size())) begin miscompares++; $display("[TB] FAIL rand_count got %0d want %0d", count_o, expQ.size()); end
      vectors++; if (overrun_o !== expOvr) begin miscompares++; $display("[TB] FAIL rand_ovr got %b want %b", overrun_o, expOvr); end
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        if (expQ.size() > 0) begin
          vectors++; if (data_o !== expQ[0]) begin miscompares++; $display("[TB] FAIL rand_data got %h want %h", data_o, expQ[0]); end
          popOne();
          void'(expQ.pop_front());
        end
      end
    end
    while (expQ.size() > 0) begin
      vectors++; if (data_o !== expQ[0]) begin miscompares++; $display("[TB] FAIL rand_drain got %h want %h", data_o, expQ[0]); end
      popOne();
      void'(expQ.pop_front());
    end
    clr_err_i = 1'b1;
    @(negedge clk_i);
    clr_err_i = 1'b0;
    expOvr = 1'b0;
    baud_div_i = 16'd16;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] last;
    for (int i = 0; i < MODEL_DEPTH; i++) begin
      last = 8'($urandom);
      sendFrame(last, 16, 0);
      modelGoodByte(last);
    end
    vectors++; if (count_o !== 3'd4) begin miscompares++; $display("[TB] FAIL full_count got %0d want 4", count_o); end
    fork
      sendFrame(8'h55, 16, 0);
      begin
        repeat (154) @(negedge clk_i);
        vectors++; if (data_o !== expQ[0]) begin miscompares++; $display("[TB] FAIL full_head got %h want %h", data_o, expQ[0]); end
        rd_i = 1'b1;
        @(negedge clk_i);
        rd_i = 1'b0;
        void'(expQ.pop_front());
        modelGoodByte(8'h55);
        vectors++; if (count_o !== 3'd4) begin miscompares++; $display("[TB] FAIL full_pushpop_count got %0d want 4", count_o); end
        vectors++; if (overrun_o !== expOvr) begin miscompares++; $display("[TB] FAIL full_pushpop_ovr got %b want %b", overrun_o, expOvr); end
      end
    join
    while (expQ.size() > 0) begin
      last = data_o;
      vectors++; if (data_o !== expQ[0]) begin miscompares++; $display("[TB] FAIL full_drain got %h want %h", data_o, expQ[0]); end
      popOne();
      void'(expQ.pop_front());
    end
    vectors++; if (last !== 8'h55) begin miscompares++; $display("[TB] FAIL full_last got %h want 55", last); end
  endtask

  task automatic test_frame_error();
    fork
      sendFrame(8'h3C, 16, 32);
      begin
        repeat (154) @(negedge clk_i);
        clr_err_i = 1'b1;
        @(negedge clk_i);
        clr_err_i = 1'b0;
        expFerr = 1'b1;
        repeat (14) @(negedge clk_i);
        vectors++; if (frame_err_o !== expFerr) begin miscompares++; $display("[TB] FAIL ferr_flag got %b want %b", frame_err_o, expFerr); end
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL ferr_wait_busy got %b want 1", busy_o); end
        vectors++; if (count_o !== 3'(expQ.size())) begin miscompares++; $display("[TB] FAIL ferr_nopush got %0d want %0d", count_o, expQ.size()); end
      end
    join
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL ferr_idle got %b want 0", busy_o); end
    sendFrame(8'h7E, 16, 0);
    modelGoodByte(8'h7E);
    vectors++; if (data_o !== expQ[0] || valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL ferr_next got %h/%b want %h/1", data_o, valid_o, expQ[0]); end
    vectors++; if (frame_err_o !== expFerr) begin miscompares++; $display("[TB] FAIL ferr_sticky got %b want %b", frame_err_o, expFerr); end
    popOne();
    void'(expQ.pop_front());
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    sendFrame(8'h9A, 16, 0);
    modelGoodByte(8'h9A);
    b = 8'hC3;
    rxd_i = 1'b0;
    repeat (16) @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      rxd_i = b[i];
      repeat (16) @(negedge clk_i);
    end
    rxd_i = b[4];
    repeat (8) @(negedge clk_i);
    rst_i = 1'b1;
    rxd_i = 1'b1;
    baud_div_i = 16'd2;
    @(negedge clk_i);
    rst_i = 1'b0;
    expQ.delete();
    expOvr = 1'b0;
    expFerr = 1'b0;
    repeat (3) @(negedge clk_i);
    vectors++; if (count_o !== 3'd0 || valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_fifo got %0d/%b want 0/0", count_o, valid_o); end
    vectors++; if ({overrun_o, frame_err_o} !== {expOvr, expFerr}) begin miscompares++; $display("[TB] FAIL rstmid_flags got %b%b want %b%b", overrun_o, frame_err_o, expOvr, expFerr); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_busy got %b want 0", busy_o); end
    b = 8'($urandom);
    sendFrame(b, 4, 0);
    modelGoodByte(b);
    vectors++; if (count_o !== 3'(expQ.size())) begin miscompares++; $display("[TB] FAIL clamp_count got %0d want %0d", count_o, expQ.size()); end
    vectors++; if (data_o !== expQ[0]) begin miscompares++; $display("[TB] FAIL clamp_data got %h want %h", data_o, expQ[0]); end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    @(negedge clk_i);
    test_reset();
    test_single_byte();
    test_glitch();
    test_overrun();
    test_random();
    test_full_push_pop();
    test_frame_error();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
